spi_regbank: RTL
================

// Module: spi_regbank
// PURPOSE
//  Parametrised, double-buffered SPI register bank; generalises the fixed six-vector POV loader to N registers of W bits.
//  An SPI master writes addressed words (with auto-increment bursts) into shadow registers.
//  Shadow registers that have been written are copied to the live outputs only on a frame-boundary pulse.
//  The live outputs therefore never change mid-frame. The block sits beside vga_sync and feeds view vectors and render settings.
// PARAMETERS
//  NUM_REGS     8     number of registers (1..2**ADDR_BITS)
//  REG_WIDTH    16    bits per register (e.g. fixed-point vector component)
//  ADDR_BITS    3     address field width in the SPI frame
//  RESET_VALUE  0     packed {reg[N-1],...,reg[0]} reset image, NUM_REGS*REG_WIDTH bits
// PORTS
//  clk           in   1                    system/pixel clock
//  reset         in   1                    async, active-high
//  i_sclk        in   1                    SPI clock, async to clk, mode 0
//  i_mosi        in   1                    SPI data, MSB first
//  i_ss_n        in   1                    SPI select, active-low
//  load_if_ready in   1                    1-cycle commit strobe (visible frame end)
//  o_regs        out  NUM_REGS*REG_WIDTH   live registers, reg[i] at [i*REG_WIDTH +: REG_WIDTH]
//  o_loaded      out  1                    1-cycle pulse: commit transferred >=1 register
//  o_abort       out  1                    1-cycle pulse: ss_n deasserted mid-word
//  o_busy        out  1                    synchronised ss_n is low
// BEHAVIOUR
//  Reset (async): o_regs and shadow = RESET_VALUE; pending[] = 0; FSM = IDLE; counters = 0; o_loaded/o_abort/o_busy = 0.
//  Sync: i_sclk, i_mosi, i_ss_n each pass through 2 flops; a 3rd sclk flop detects rising edges.
//    Required: f_sclk <= f_clk/4, and sclk high/low each >= 2 clk periods.
//  Sampling: mosi (synchronised) is shifted on each detected sclk rise; the edge is acted on <=3 clk after the pin edge.
//  Frame (one ss_n assertion): ADDR_BITS address bits, then 1..k words of REG_WIDTH data bits each.
//  FSM:
//    IDLE -> ADDR on ss_n fall; bit counter = 0.
//    ADDR: shift address bits; after ADDR_BITS bits -> DATA, ptr = address.
//    DATA: shift data bits; after REG_WIDTH bits:
//      - if ptr < NUM_REGS: shadow[ptr] <= word and pending[ptr] <= 1; otherwise the word is dropped silently.
//      - ptr <= (ptr == NUM_REGS-1) ? 0 : ptr+1; the addressed wrap applies even if ptr >= NUM_REGS (it then increments modulo 2**ADDR_BITS).
//      - bit counter restarts; the FSM stays in DATA.
//    Any state -> IDLE on ss_n rise.
//      - o_abort pulses only if the ss_n rise occurs with a partial address or partial word (bit count != 0).
//      - A partial word never reaches the shadow.
//  Commit: on a load_if_ready cycle, every reg i with pending[i] = 1 copies shadow[i] to o_regs[i], and its pending bit clears.
//    o_loaded pulses next cycle iff any pending bit was set. With no pending bits, o_regs is unchanged and there is no pulse.
//  Simultaneous word-complete and load_if_ready on the same cycle:
//    - the commit uses the pre-edge shadow/pending;
//    - the newly completed word lands in the shadow with pending = 1, so it commits at the NEXT load_if_ready;
//    - a same-register overlap gives o_regs = old shadow, shadow = new word, pending = 1.
//  Repeated writes to one register before a commit: last write wins.
//  Reset asserted mid-frame: everything returns to reset image. After reset, ss_n already low is ignored until it goes high then low.
//  load_if_ready is independent of SPI activity; an active frame continues across the commit.
// TESTING
//  1. Reset, no SPI -> o_regs == RESET_VALUE; load_if_ready pulses -> o_regs unchanged, o_loaded stays 0.
//  2. Write addr 2 data 16'h1234, no load -> o_regs[2] unchanged. Pulse load -> o_regs[2] = 16'h1234 next cycle, o_loaded = 1 for 1 cycle.
//  3. Burst at addr 7 with data A,B,C (NUM_REGS = 8) -> regs 7, 0, 1 = A, B, C after a single load; the other regs are unchanged.
//  4. ss_n raised after 9 data bits -> o_abort pulse; shadow/pending unchanged; a following full frame works normally.
//  5. load_if_ready on the exact cycle a word to reg 3 completes -> o_regs[3] keeps its old value; the next load gives the new word.
//  6. Assert reset mid-word with 8'hFF pending in reg 0 -> o_regs = RESET_VALUE; the next load has no effect; SPI idle until ss_n cycles.

Source files
------------

// File: rtl/spi_regbank.sv
// Double-buffered register bank loaded over a mode-0 SPI link.
// The SPI master writes addressed words, with auto-increment bursts, into shadow registers.
// Each shadow register that has been written is copied to the live outputs on a commit strobe,
// so the live image changes only at frame boundaries.
//
// state  | meaning
// S_IDLE | select inactive, or not yet seen high since reset
// S_ADDR | shifting in the address field
// S_DATA | shifting in data words; pointer auto-increments after each word
module spi_regbank #(
  parameter int NUM_REGS  = 8,
  parameter int REG_WIDTH = 16,
  parameter int ADDR_BITS = 3,
  parameter logic [NUM_REGS*REG_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_sclk,
  input  logic                          i_mosi,
  input  logic                          i_ss_n,
  input  logic                          load_if_ready,
  output logic [NUM_REGS*REG_WIDTH-1:0] o_regs,
  output logic                          o_loaded,
  output logic                          o_abort,
  output logic                          o_busy
);

  // One shift register serves both fields, so it must hold the wider of the two.
  localparam int SH_W  = (REG_WIDTH > ADDR_BITS) ? REG_WIDTH : ADDR_BITS;
  localparam int CNT_W = $clog2(SH_W + 1);

  localparam logic [CNT_W-1:0]     ADDR_LAST = CNT_W'(ADDR_BITS - 1);
  localparam logic [CNT_W-1:0]     WORD_LAST = CNT_W'(REG_WIDTH - 1);
  localparam logic [ADDR_BITS-1:0] PTR_LAST  = ADDR_BITS'(NUM_REGS - 1);
  localparam logic [ADDR_BITS:0]   PTR_LIMIT = (ADDR_BITS + 1)'(NUM_REGS);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  logic [2:0] sclk_q;
  logic [1:0] mosi_q;
  logic [1:0] ss_q;
  logic       ss_prev_q;
  logic       armed_q;

  logic sclk_rise;
  logic mosi_s;
  logic ss_s;
  logic ss_fall;
  logic ss_rise;

  // Synchronise the SPI pins. The select flops reset low, so a select that is already low
  // when reset releases never produces a falling edge; the master has to cycle it first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_q    <= '0;
      mosi_q    <= '0;
      ss_q      <= '0;
      ss_prev_q <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      sclk_q    <= {sclk_q[1:0], i_sclk};
      mosi_q    <= {mosi_q[0], i_mosi};
      ss_q      <= {ss_q[0], i_ss_n};
      ss_prev_q <= ss_q[1];
      if (ss_q[1]) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign mosi_s    = mosi_q[1];
  assign ss_s      = ss_q[1];
  assign ss_fall   = ss_prev_q & ~ss_s;
  assign ss_rise   = ~ss_prev_q & ss_s;
  assign o_busy    = armed_q & ~ss_s;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SH_W-1:0]      shift_q, shift_d;
  logic [ADDR_BITS-1:0] ptr_q, ptr_d;
  logic                 abort_q, abort_d;

  logic [SH_W:0]          shift_ext;
  logic [SH_W-1:0]        shift_nxt;
  logic                   word_done;
  logic                   word_in_range;
  logic [REG_WIDTH-1:0]   word_data;

  assign shift_ext     = {shift_q, mosi_s};
  assign shift_nxt     = shift_ext[SH_W-1:0];
  assign word_data     = shift_nxt[REG_WIDTH-1:0];
  assign word_in_range = ({1'b0, ptr_q} < PTR_LIMIT);

  // Frame FSM state, bit counter, shift register and word pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      ptr_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      ptr_q   <= ptr_d;
      abort_q <= abort_d;
    end
  end

  // Next-state logic: a select release always wins, and only flags an abort with bits in flight.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    abort_d   = 1'b0;
    word_done = 1'b0;
    if (ss_rise) begin
      abort_d = (state_q != S_IDLE) && (cnt_q != '0);
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ss_fall) begin
            state_d = S_ADDR;
            cnt_d   = '0;
          end
        end
        S_ADDR: begin
          if (sclk_rise) begin
            shift_d = shift_nxt;
            if (cnt_q == ADDR_LAST) begin
              state_d = S_DATA;
              cnt_d   = '0;
              ptr_d   = shift_nxt[ADDR_BITS-1:0];
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        S_DATA: begin
          if (sclk_rise) begin
            shift_d = shift_nxt;
            if (cnt_q == WORD_LAST) begin
              word_done = 1'b1;
              cnt_d     = '0;
              // Wraps at the last implemented register; out-of-range pointers count on modulo 2**ADDR_BITS.
              ptr_d     = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign o_abort = abort_q;

  logic [REG_WIDTH-1:0] shadow_q [NUM_REGS];
  logic [REG_WIDTH-1:0] shadow_d [NUM_REGS];
  logic [REG_WIDTH-1:0] live_q   [NUM_REGS];
  logic [REG_WIDTH-1:0] live_d   [NUM_REGS];
  logic [NUM_REGS-1:0]  pending_q, pending_d;
  logic                 loaded_q, loaded_d;

  // Shadow, pending and live registers; every register returns to its slice of the reset image.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_q[i] <= RESET_VALUE[i*REG_WIDTH +: REG_WIDTH];
        live_q[i]   <= RESET_VALUE[i*REG_WIDTH +: REG_WIDTH];
      end
      pending_q <= '0;
      loaded_q  <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      live_q    <= live_d;
      pending_q <= pending_d;
      loaded_q  <= loaded_d;
    end
  end

  // Commit reads only pre-edge shadow/pending, and a word finishing on the same cycle sets
  // pending after the commit clears it, so that word waits for the next strobe.
  always_comb begin
    shadow_d  = shadow_q;
    live_d    = live_q;
    pending_d = pending_q;
    loaded_d  = load_if_ready && (|pending_q);
    for (int i = 0; i < NUM_REGS; i++) begin
      if (load_if_ready && pending_q[i]) begin
        live_d[i]    = shadow_q[i];
        pending_d[i] = 1'b0;
      end
      if (word_done && word_in_range && (ptr_q == ADDR_BITS'(i))) begin
        shadow_d[i]  = word_data;
        pending_d[i] = 1'b1;
      end
    end
  end

  assign o_loaded = loaded_q;

  // Flatten the live registers onto the output bus, register i at [i*REG_WIDTH +: REG_WIDTH].
  always_comb begin
    o_regs = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      o_regs[i*REG_WIDTH +: REG_WIDTH] = live_q[i];
    end
  end

endmodule
